pipeline_ctrl: RTL and testbench

Stall/flush controller for the five-stage pipeline. It drives the load enables and bubble-insert (flush) controls of the four inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold. It resolves load-use hazards, taken-branch redirects and multi-cycle RAM accesses, and latches a sticky error if RAM never answers. It sits beside the datapath and consumes decode fields plus the control bits (wE_BR, R_ram, W_ram) already carried by the ID/EX buffer.

---
 rtl/pipeline_ctrl_if.sv | 42 ++++
 rtl/pipeline_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the five-stage datapath and its stall/flush controller.
// master = datapath side (decode/hazard fields out), slave = controller side.
interface pipeline_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs2;
  logic                  ex_R_ram;
  logic                  ex_wE_BR;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  branch_taken;

  logic                  stall_if;
  logic                  en_buf1;
  logic                  en_buf2;
  logic                  en_buf3;
  logic                  en_buf4;
  logic                  flush_buf1;
  logic                  flush_buf2;
  logic                  mem_timeout;
  logic [15:0]           stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2,
    output ex_R_ram, ex_wE_BR, ex_rd,
    output mem_req, mem_ready, branch_taken,
    input  stall_if, en_buf1, en_buf2, en_buf3, en_buf4,
    input  flush_buf1, flush_buf2, mem_timeout, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2,
    input  ex_R_ram, ex_wE_BR, ex_rd,
    input  mem_req, mem_ready, branch_taken,
    output stall_if, en_buf1, en_buf2, en_buf3, en_buf4,
    output flush_buf1, flush_buf2, mem_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: load-use stalls, branch flushes, RAM wait freezes
// and a sticky timeout error for the five-stage pipeline.
module pipeline_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave bus
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WAIT_W-1:0]     wait_cnt_nxt;
  logic [15:0]           stall_cnt;

  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic                  hazard;
  logic                  freeze;

  logic                  run_stall;
  logic                  run_en1;
  logic                  run_flush1;
  logic                  run_flush2;

  logic                  stall;
  logic                  en1;
  logic                  en_rest;
  logic                  flush1;
  logic                  flush2;

  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;
  assign rd  = bus.ex_rd;

  assign hazard = bus.id_valid && bus.ex_R_ram && bus.ex_wE_BR && (rd != '0) &&
                  ((rd == rs1) || (bus.id_uses_rs2 && (rd == rs2)));

  // Branch outranks the load-use stall: the hazarding ID instruction is flushed.
  always_comb begin
    run_stall  = 1'b0;
    run_en1    = 1'b1;
    run_flush1 = 1'b0;
    run_flush2 = 1'b0;
    if (bus.branch_taken) begin
      run_flush1 = 1'b1;
      run_flush2 = 1'b1;
    end else if (hazard) begin
      run_stall  = 1'b1;
      run_en1    = 1'b0;
      run_flush2 = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze       = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (!bus.mem_ready) begin
          freeze = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERROR;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        freeze    = 1'b1;
        state_nxt = RUN;
      end
    endcase
  end

  // Reset forces the frozen pattern asynchronously, independent of state.
  always_comb begin
    stall   = run_stall;
    en1     = run_en1;
    en_rest = 1'b1;
    flush1  = run_flush1;
    flush2  = run_flush2;
    if (freeze || !rst_n) begin
      stall   = 1'b1;
      en1     = 1'b0;
      en_rest = 1'b0;
      flush1  = 1'b0;
      flush2  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall && (state != ERROR) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign bus.stall_if    = stall;
  assign bus.en_buf1     = en1;
  assign bus.en_buf2     = en_rest;
  assign bus.en_buf3     = en_rest;
  assign bus.en_buf4     = en_rest;
  assign bus.flush_buf1  = flush1;
  assign bus.flush_buf2  = flush2;
  assign bus.mem_timeout = (state == ERROR);
  assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 4;

  // {stall_if, en_buf1..4, flush_buf1, flush_buf2, mem_timeout}
  localparam logic [7:0] C_IDLE   = 8'b0111_1000;
  localparam logic [7:0] C_BRANCH = 8'b0111_1110;
  localparam logic [7:0] C_HAZARD = 8'b1011_1010;
  localparam logic [7:0] C_FREEZE = 8'b1000_0000;
  localparam logic [7:0] C_ERROR  = 8'b1000_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // model: m_wait < 0 means no RAM wait open, else low-ready wait cycles seen
  int m_wait   = -1;
  bit m_err    = 1'b0;
  int m_stalls = 0;

  pipeline_ctrl_if #(.REG_ADDR_W(5)) bus ();

  pipeline_ctrl #(
    .REG_ADDR_W (5),
    .MEM_TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_ctl();
    return {bus.stall_if, bus.en_buf1, bus.en_buf2, bus.en_buf3, bus.en_buf4,
            bus.flush_buf1, bus.flush_buf2, bus.mem_timeout};
  endfunction

  function automatic logic [7:0] model_ctl();
    bit hz;
    bit frz;
    hz = bus.id_valid && bus.ex_R_ram && bus.ex_wE_BR && (bus.ex_rd != 0) &&
         ((bus.ex_rd == bus.id_rs1) || (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
    if (!rst_n) return C_FREEZE;
    if (m_err) return C_ERROR;
    frz = (m_wait < 0) ? (bus.mem_req && !bus.mem_ready) : !bus.mem_ready;
    if (frz) return C_FREEZE;
    if (bus.branch_taken) return C_BRANCH;
    if (hz) return C_HAZARD;
    return C_IDLE;
  endfunction

  function automatic void model_clock();
    logic [7:0] e;
    e = model_ctl();
    if (!rst_n) return;
    if (e[7] && !m_err && m_stalls < 65535) m_stalls++;
    if (m_err) return;
    if (m_wait < 0) begin
      if (bus.mem_req && !bus.mem_ready) m_wait = 0;
    end else if (bus.mem_ready) begin
      m_wait = -1;
    end else begin
      m_wait++;
      if (m_wait == TIMEOUT) m_err = 1'b1;
    end
  endfunction

  task automatic idle();
    bus.id_valid     = 1'b0;
    bus.id_rs1       = '0;
    bus.id_rs2       = '0;
    bus.id_uses_rs2  = 1'b0;
    bus.ex_R_ram     = 1'b0;
    bus.ex_wE_BR     = 1'b0;
    bus.ex_rd        = '0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    m_wait = -1;
    m_err = 1'b0;
    m_stalls = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_hazard(input logic [4:0] rd);
    bus.id_valid = 1'b1;
    bus.ex_R_ram = 1'b1;
    bus.ex_wE_BR = 1'b1;
    bus.ex_rd    = rd;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (dut_ctl() !== C_FREEZE) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want %b", dut_ctl(), C_FREEZE);
    end
    n_checks++;
    if (bus.stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d want 0", bus.stall_count);
    end
    rst_n = 1'b1;
    #3;
    n_checks++;
    if (dut_ctl() !== C_IDLE) begin
      n_fail++;
      $display("FAIL reset_release_ctl got %b want %b", dut_ctl(), C_IDLE);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    load_hazard(5'd5);
    bus.id_rs1 = 5'd5;
    #3;
    n_checks++;
    if (dut_ctl() !== C_HAZARD) begin
      n_fail++;
      $display("FAIL load_use_ctl got %b want %b", dut_ctl(), C_HAZARD);
    end
    tick();
    n_checks++;
    if (bus.stall_count !== 16'd1) begin
      n_fail++;
      $display("FAIL load_use_count got %0d want 1", bus.stall_count);
    end
    bus.ex_rd  = 5'd0;
    bus.id_rs1 = 5'd0;
    #3;
    n_checks++;
    if (dut_ctl() !== C_IDLE) begin
      n_fail++;
      $display("FAIL load_use_rd0_ctl got %b want %b", dut_ctl(), C_IDLE);
    end
    tick();
    bus.ex_rd       = 5'd7;
    bus.id_rs1      = 5'd3;
    bus.id_rs2      = 5'd7;
    bus.id_uses_rs2 = 1'b1;
    #3;
    n_checks++;
    if (dut_ctl() !== C_HAZARD) begin
      n_fail++;
      $display("FAIL load_use_rs2_ctl got %b want %b", dut_ctl(), C_HAZARD);
    end
    tick();
    bus.id_uses_rs2 = 1'b0;
    #3;
    n_checks++;
    if (dut_ctl() !== C_IDLE) begin
      n_fail++;
      $display("FAIL load_use_rs2_unused_ctl got %b want %b", dut_ctl(), C_IDLE);
    end
    tick();
    n_checks++;
    if (bus.stall_count !== 16'd2) begin
      n_fail++;
      $display("FAIL load_use_count2 got %0d want 2", bus.stall_count);
    end
  endtask

  task automatic test_branch();
    do_reset();
    load_hazard(5'd9);
    bus.id_rs1       = 5'd9;
    bus.branch_taken = 1'b1;
    #3;
    n_checks++;
    if (dut_ctl() !== C_BRANCH) begin
      n_fail++;
      $display("FAIL branch_hazard_ctl got %b want %b", dut_ctl(), C_BRANCH);
    end
    tick();
    n_checks++;
    if (bus.stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL branch_count got %0d want 0", bus.stall_count);
    end
  endtask

  task automatic test_ram_wait();
    do_reset();
    bus.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      n_checks++;
      if (dut_ctl() !== C_FREEZE) begin
        n_fail++;
        $display("FAIL ram_wait_freeze%0d got %b want %b", i, dut_ctl(), C_FREEZE);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    #3;
    n_checks++;
    if (dut_ctl() !== C_IDLE) begin
      n_fail++;
      $display("FAIL ram_wait_release got %b want %b", dut_ctl(), C_IDLE);
    end
    tick();
    idle();
    #3;
    n_checks++;
    if (dut_ctl() !== C_IDLE || bus.stall_count !== 16'd3) begin
      n_fail++;
      $display("FAIL ram_wait_after got %b/%0d want %b/3", dut_ctl(), bus.stall_count, C_IDLE);
    end
    tick();
    // branch arriving during a freeze is held until the release cycle
    bus.mem_req      = 1'b1;
    bus.branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      n_checks++;
      if (dut_ctl() !== C_FREEZE) begin
        n_fail++;
        $display("FAIL ram_branch_freeze%0d got %b want %b", i, dut_ctl(), C_FREEZE);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    #3;
    n_checks++;
    if (dut_ctl() !== C_BRANCH) begin
      n_fail++;
      $display("FAIL ram_branch_release got %b want %b", dut_ctl(), C_BRANCH);
    end
    tick();
  endtask

  task automatic test_timeout();
    // ready on the last tolerated wait cycle: no error
    do_reset();
    bus.mem_req = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) tick();
    bus.mem_ready = 1'b1;
    #3;
    n_checks++;
    if (dut_ctl() !== C_IDLE) begin
      n_fail++;
      $display("FAIL timeout_edge_release got %b want %b", dut_ctl(), C_IDLE);
    end
    tick();
    idle();
    #3;
    n_checks++;
    if (dut_ctl() !== C_IDLE || bus.stall_count !== 16'(TIMEOUT)) begin
      n_fail++;
      $display("FAIL timeout_edge_after got %b/%0d want %b/%0d", dut_ctl(), bus.stall_count,
               C_IDLE, TIMEOUT);
    end
    do_reset();
    bus.mem_req = 1'b1;
    for (int i = 0; i < TIMEOUT + 1; i++) begin
      #3;
      n_checks++;
      if (dut_ctl() !== C_FREEZE) begin
        n_fail++;
        $display("FAIL timeout_freeze%0d got %b want %b", i, dut_ctl(), C_FREEZE);
      end
      tick();
    end
    n_checks++;
    if (dut_ctl() !== C_ERROR || bus.stall_count !== 16'd5) begin
      n_fail++;
      $display("FAIL timeout_error got %b/%0d want %b/5", dut_ctl(), bus.stall_count, C_ERROR);
    end
    bus.mem_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (dut_ctl() !== C_ERROR || bus.stall_count !== 16'd5) begin
      n_fail++;
      $display("FAIL timeout_sticky got %b/%0d want %b/5", dut_ctl(), bus.stall_count, C_ERROR);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_ctl() !== C_FREEZE || bus.stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_in_error got %b/%0d want %b/0", dut_ctl(), bus.stall_count, C_FREEZE);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    bus.mem_req = 1'b1;
    tick();
    tick();
    bus.mem_ready    = 1'b1;
    bus.branch_taken = 1'b1;
    #1;
    n_checks++;
    if (dut_ctl() !== C_BRANCH) begin
      n_fail++;
      $display("FAIL midwait_release_ctl got %b want %b", dut_ctl(), C_BRANCH);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_ctl() !== C_FREEZE || bus.stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midwait_async_reset got %b/%0d want %b/0", dut_ctl(), bus.stall_count, C_FREEZE);
    end
    do_reset();
    #3;
    n_checks++;
    if (dut_ctl() !== C_IDLE || bus.stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midwait_after got %b/%0d want %b/0", dut_ctl(), bus.stall_count, C_IDLE);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 0) do_reset();
      bus.id_valid     = ($urandom_range(0, 3) != 0);
      bus.id_rs1       = 5'($urandom_range(0, 3));
      bus.id_rs2       = 5'($urandom_range(0, 3));
      bus.id_uses_rs2  = 1'($urandom_range(0, 1));
      bus.ex_R_ram     = 1'($urandom_range(0, 1));
      bus.ex_wE_BR     = ($urandom_range(0, 3) != 0);
      bus.ex_rd        = 5'($urandom_range(0, 3));
      bus.mem_req      = ($urandom_range(0, 3) == 0);
      bus.mem_ready    = ($urandom_range(0, 2) != 0);
      bus.branch_taken = ($urandom_range(0, 5) == 0);
      #3;
      exp = model_ctl();
      n_checks++;
      if (dut_ctl() !== exp) begin
        n_fail++;
        $display("FAIL random_ctl cycle %0d got %b want %b", i, dut_ctl(), exp);
      end
      n_checks++;
      if (bus.stall_count !== 16'(m_stalls)) begin
        n_fail++;
        $display("FAIL random_count cycle %0d got %0d want %0d", i, bus.stall_count, m_stalls);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    load_hazard(5'd4);
    bus.id_rs1 = 5'd4;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    n_checks++;
    if (dut_ctl() !== C_HAZARD || bus.stall_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturation got %b/%h want %b/ffff", dut_ctl(), bus.stall_count, C_HAZARD);
    end
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    n_checks++;
    if (bus.stall_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL saturation_hold got %h want ffff", bus.stall_count);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_ram_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
